fm_tune_ctrl: RTL and testbench

Channel tuning and scan controller for the FM demodulator. It drives the NCO phase increment, mutes the DA output while the I/Q FIR chain settles after a retune, and measures mean I/Q magnitude to decide carrier lock. It also auto-scans the channel raster for the next occupied channel. It sits beside the NCO/mixer/FIR datapath and takes the post-FIR I/Q samples as its measurement input.

---
 rtl/fm_tune_ctrl.sv | 254 +++++++++++++++++++++++++
 tb/tb_fm_tune_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fm_tune_ctrl.sv
// fm_tune_ctrl: channel tuning and scan controller for the FM demodulator.
// Programs the NCO phase increment for a channel, mutes the DA output while
// the I/Q FIR chain settles, measures mean |I|+|Q| over a fixed window of
// valid samples and decides carrier lock. A scan walks the channel raster
// (with wrap) until a locked channel is found or it returns to its start.
// Optional feature macro: FM_TUNE_RELOCK_EN -- continuous re-measurement in
// TRACK with an automatic up-scan after two consecutive unlocked windows.
module fm_tune_ctrl #(
    parameter int PHI_W      = 16,
    parameter int PHI_BASE   = 1311,
    parameter int INC_STEP   = 131,
    parameter int CH_MAX     = 31,
    parameter int SETTLE_CYC = 256,
    parameter int DWELL_LOG2 = 10,
    parameter int THRESH     = 200
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               tune_req,
    input  logic [5:0]         tune_ch,
    input  logic               scan_req,
    input  logic               scan_up,
    input  logic               iq_valid,
    input  logic signed [11:0] i_data,
    input  logic signed [11:0] q_data,
    output logic [PHI_W-1:0]   phi_inc,
    output logic               mute,
    output logic               busy,
    output logic               lock,
    output logic [5:0]         cur_ch,
    output logic [12:0]        pwr,
    output logic               done
);

    localparam int ACC_W = 13 + DWELL_LOG2;
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [SET_W-1:0]      SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [SET_W-1:0]      SET_ONE     = SET_W'(1);
    localparam logic [DWELL_LOG2-1:0] SAMP_ONE    = DWELL_LOG2'(1);
    localparam logic [5:0]            CH_MAX_C    = 6'(CH_MAX);
    localparam logic [12:0]           THRESH_C    = 13'(THRESH);
    localparam logic [PHI_W-1:0]      PHI_RST     = PHI_W'(PHI_BASE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_MEASURE,
        S_DECIDE,
        S_TRACK
    } state_t;

    state_t                  state_reg;
    logic [SET_W-1:0]        settle_cnt_reg;
    logic [DWELL_LOG2-1:0]   sample_cnt_reg;
    logic [ACC_W-1:0]        acc_reg;
    logic                    scan_mode_reg;
    logic                    scan_dir_reg;
    logic [5:0]              scan_start_reg;

    // NCO increment for a channel; wraps naturally at PHI_W bits.
    function automatic logic [PHI_W-1:0] phi_of(input logic [5:0] ch);
        logic [31:0] full;
        full = 32'(PHI_BASE) + 32'(ch) * 32'(INC_STEP);
        return full[PHI_W-1:0];
    endfunction

    // One raster step in the given direction, wrapping CH_MAX <-> 0.
    function automatic logic [5:0] step_ch(input logic [5:0] ch, input logic up);
        if (up) begin
            return (ch >= CH_MAX_C) ? 6'd0 : ch + 6'd1;
        end
        return (ch == 6'd0) ? CH_MAX_C : ch - 6'd1;
    endfunction

    // Magnitude of each lane as a 12-bit unsigned value, so -2048 maps to 2048.
    logic [11:0] lane_raw [2];
    logic [11:0] lane_abs [2];

    assign lane_raw[0] = i_data;
    assign lane_raw[1] = q_data;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_abs
            assign lane_abs[gi] = lane_raw[gi][11] ? (~lane_raw[gi] + 12'd1) : lane_raw[gi];
        end
    endgenerate

    logic [12:0]      samp_sum;
    logic [ACC_W-1:0] acc_next;
    logic [12:0]      win_mean;
    logic             win_last;
    logic             pwr_hit;
    logic [5:0]       tune_ch_clamped;
    logic [5:0]       scan_next_ch;

    assign samp_sum        = {1'b0, lane_abs[0]} + {1'b0, lane_abs[1]};
    assign acc_next        = acc_reg + ACC_W'(samp_sum);
    assign win_mean        = acc_next[ACC_W-1:DWELL_LOG2];
    assign win_last        = &sample_cnt_reg;
    assign pwr_hit         = (pwr >= THRESH_C);
    assign tune_ch_clamped = (tune_ch > CH_MAX_C) ? CH_MAX_C : tune_ch;
    assign scan_next_ch    = step_ch(cur_ch, scan_dir_reg);

`ifdef FM_TUNE_RELOCK_EN
    logic mean_hit;
    logic miss_reg;
    assign mean_hit = (win_mean >= THRESH_C);
`endif

    // Control FSM: requests pre-empt the state flow, all outputs are registered.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_reg      <= S_IDLE;
            settle_cnt_reg <= '0;
            sample_cnt_reg <= '0;
            acc_reg        <= '0;
            scan_mode_reg  <= 1'b0;
            scan_dir_reg   <= 1'b0;
            scan_start_reg <= '0;
            phi_inc        <= PHI_RST;
            mute           <= 1'b1;
            busy           <= 1'b0;
            lock           <= 1'b0;
            cur_ch         <= '0;
            pwr            <= '0;
            done           <= 1'b0;
`ifdef FM_TUNE_RELOCK_EN
            miss_reg       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (tune_req) begin
                // A manual tune aborts anything in flight, including a scan.
                cur_ch        <= tune_ch_clamped;
                scan_mode_reg <= 1'b0;
                state_reg     <= S_LOAD;
                busy          <= 1'b1;
                mute          <= 1'b1;
                lock          <= 1'b0;
            end else if (scan_req && (state_reg == S_IDLE || state_reg == S_TRACK)) begin
                // The scan never re-measures its start channel first.
                scan_mode_reg  <= 1'b1;
                scan_dir_reg   <= scan_up;
                scan_start_reg <= cur_ch;
                cur_ch         <= step_ch(cur_ch, scan_up);
                state_reg      <= S_LOAD;
                busy           <= 1'b1;
                mute           <= 1'b1;
                lock           <= 1'b0;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        state_reg <= S_IDLE;
                    end
                    S_LOAD: begin
                        phi_inc        <= phi_of(cur_ch);
                        settle_cnt_reg <= '0;
                        sample_cnt_reg <= '0;
                        acc_reg        <= '0;
                        state_reg      <= S_SETTLE;
                    end
                    S_SETTLE: begin
                        if (settle_cnt_reg == SETTLE_LAST) begin
                            state_reg <= S_MEASURE;
                        end else begin
                            settle_cnt_reg <= settle_cnt_reg + SET_ONE;
                        end
                    end
                    S_MEASURE: begin
                        // Stalls indefinitely while no valid samples arrive.
                        if (iq_valid) begin
                            acc_reg        <= acc_next;
                            sample_cnt_reg <= sample_cnt_reg + SAMP_ONE;
                            if (win_last) begin
                                pwr       <= win_mean;
                                state_reg <= S_DECIDE;
                            end
                        end
                    end
                    S_DECIDE: begin
                        if (!scan_mode_reg || pwr_hit) begin
                            lock           <= pwr_hit;
                            mute           <= ~pwr_hit;
                            busy           <= 1'b0;
                            done           <= 1'b1;
                            acc_reg        <= '0;
                            sample_cnt_reg <= '0;
                            state_reg      <= S_TRACK;
`ifdef FM_TUNE_RELOCK_EN
                            miss_reg       <= 1'b0;
`endif
                        end else if (scan_next_ch == scan_start_reg) begin
                            // Full lap without a carrier: park back on the start channel.
                            cur_ch         <= scan_start_reg;
                            phi_inc        <= phi_of(scan_start_reg);
                            lock           <= 1'b0;
                            mute           <= 1'b1;
                            busy           <= 1'b0;
                            done           <= 1'b1;
                            acc_reg        <= '0;
                            sample_cnt_reg <= '0;
                            state_reg      <= S_TRACK;
`ifdef FM_TUNE_RELOCK_EN
                            miss_reg       <= 1'b0;
`endif
                        end else begin
                            cur_ch    <= scan_next_ch;
                            state_reg <= S_LOAD;
                        end
                    end
                    S_TRACK: begin
`ifdef FM_TUNE_RELOCK_EN
                        // Rolling windows keep lock/pwr fresh; two misses in a row trigger an up-scan.
                        if (iq_valid) begin
                            acc_reg        <= acc_next;
                            sample_cnt_reg <= sample_cnt_reg + SAMP_ONE;
                            if (win_last) begin
                                acc_reg <= '0;
                                pwr     <= win_mean;
                                lock    <= mean_hit;
                                mute    <= ~mean_hit;
                                if (mean_hit) begin
                                    miss_reg <= 1'b0;
                                end else if (miss_reg) begin
                                    miss_reg       <= 1'b0;
                                    scan_mode_reg  <= 1'b1;
                                    scan_dir_reg   <= 1'b1;
                                    scan_start_reg <= cur_ch;
                                    cur_ch         <= step_ch(cur_ch, 1'b1);
                                    state_reg      <= S_LOAD;
                                    busy           <= 1'b1;
                                    mute           <= 1'b1;
                                    lock           <= 1'b0;
                                end else begin
                                    miss_reg <= 1'b1;
                                end
                            end
                        end
`else
                        state_reg <= S_TRACK;
`endif
                    end
                    default: begin
                        state_reg <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fm_tune_ctrl.sv
// Bench for fm_tune_ctrl: randomized I/Q stimulus against a window-sum model,
// scan path model over the channel raster, abort/clamp/reset scenarios.
module tb_fm_tune_ctrl;

    localparam int PHI_W      = 16;
    localparam int PHI_BASE   = 1311;
    localparam int INC_STEP   = 131;
    localparam int CH_MAX     = 31;
    localparam int SETTLE_CYC = 256;
    localparam int DWELL_LOG2 = 10;
    localparam int THRESH     = 200;
    localparam int WIN        = 1 << DWELL_LOG2;
    // Cycle numbering: request sampled at edge t, done seen in cycle t+LATENCY,
    // i.e. LATENCY-1 clock edges after the request edge.
    localparam int LATENCY    = 2 + SETTLE_CYC + WIN + 1;
    localparam int MEAS_START = 2 + SETTLE_CYC;
    localparam int MEAS_BOUND = 8000;
    localparam int SCAN_BOUND = 45000;

    logic               sys_clk;
    logic               sys_rst;
    logic               tune_req;
    logic [5:0]         tune_ch;
    logic               scan_req;
    logic               scan_up;
    logic               iq_valid;
    logic signed [11:0] i_data;
    logic signed [11:0] q_data;
    logic [PHI_W-1:0]   phi_inc;
    logic               mute;
    logic               busy;
    logic               lock;
    logic [5:0]         cur_ch;
    logic [12:0]        pwr;
    logic               done;

    int checks = 0;
    int errors = 0;
    int cur_i, cur_q;
    bit cur_v;
    int visited_q[$];
    int exp_path[$];

    fm_tune_ctrl #(
        .PHI_W(PHI_W), .PHI_BASE(PHI_BASE), .INC_STEP(INC_STEP), .CH_MAX(CH_MAX),
        .SETTLE_CYC(SETTLE_CYC), .DWELL_LOG2(DWELL_LOG2), .THRESH(THRESH)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .tune_req(tune_req), .tune_ch(tune_ch),
        .scan_req(scan_req), .scan_up(scan_up), .iq_valid(iq_valid),
        .i_data(i_data), .q_data(q_data), .phi_inc(phi_inc), .mute(mute),
        .busy(busy), .lock(lock), .cur_ch(cur_ch), .pwr(pwr), .done(done)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic int phi_of(input int ch);
        return (PHI_BASE + ch * INC_STEP) % (1 << PHI_W);
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic drive_sample(input int imin, input int imax, input int vpct);
        cur_i = imin + int'($urandom_range(imax - imin));
        cur_q = imin + int'($urandom_range(imax - imin));
        cur_v = ($urandom_range(99) < vpct);
        i_data   = 12'(cur_i);
        q_data   = 12'(cur_q);
        iq_valid = cur_v;
    endtask

    // Present a request for exactly one sampling edge.
    task automatic issue(input bit t, input int ch, input bit s, input bit up);
        @(negedge sys_clk);
        tune_req = t;
        tune_ch  = 6'(ch);
        scan_req = s;
        scan_up  = up;
        @(posedge sys_clk);
        #1;
        tune_req = 1'b0;
        scan_req = 1'b0;
    endtask

    // Drive random samples after a request edge; the model sums the first WIN
    // valid samples that arrive once the settle period is over.
    task automatic measure(input int imin, input int imax, input int vpct,
                           output int edges, output int exp_edges, output int exp_pwr);
        int k = 0;
        int n = 0;
        longint sum = 0;
        edges = -1;
        exp_edges = -2;
        while (k < MEAS_BOUND) begin
            @(negedge sys_clk);
            if (done === 1'b1) begin
                edges = k;
                break;
            end
            drive_sample(imin, imax, vpct);
            @(posedge sys_clk);
            k++;
            if (k >= MEAS_START && cur_v && n < WIN) begin
                sum += longint'(iabs(cur_i) + iabs(cur_q));
                n++;
                if (n == WIN) exp_edges = k + 1;
            end
        end
        exp_pwr = int'(sum >> DWELL_LOG2);
    endtask

    // Radio model: a carrier appears only when the NCO sits on sig_ch.
    task automatic scan_drive(input int sig_ch, input int noise, output int edges, output int ndone);
        int k = 0;
        int prev;
        visited_q.delete();
        prev = int'(phi_inc);
        edges = -1;
        ndone = 0;
        while (k < SCAN_BOUND) begin
            @(negedge sys_clk);
            if (busy === 1'b1 && int'(phi_inc) != prev) visited_q.push_back(int'(phi_inc));
            prev = int'(phi_inc);
            if (done === 1'b1) begin
                ndone++;
                edges = k;
                break;
            end
            if (sig_ch >= 0 && int'(phi_inc) == phi_of(sig_ch)) drive_sample(150, 150, 100);
            else drive_sample(-noise, noise, 100);
            @(posedge sys_clk);
            k++;
        end
        repeat (30) begin
            @(negedge sys_clk);
            if (done === 1'b1) ndone++;
        end
    endtask

    task automatic test_reset();
        sys_rst = 1'b0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        checks++; if (phi_inc !== 16'(PHI_BASE)) begin errors++; $display("FAIL reset_phi_inc: got %0d expected %0d", phi_inc, PHI_BASE); end
        checks++; if (mute !== 1'b1) begin errors++; $display("FAIL reset_mute: got %b expected 1", mute); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (lock !== 1'b0) begin errors++; $display("FAIL reset_lock: got %b expected 0", lock); end
        checks++; if (cur_ch !== 6'd0) begin errors++; $display("FAIL reset_cur_ch: got %0d expected 0", cur_ch); end
        checks++; if (pwr !== 13'd0) begin errors++; $display("FAIL reset_pwr: got %0d expected 0", pwr); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        sys_rst = 1'b1;
        repeat (5) @(negedge sys_clk);
        checks++; if (phi_inc !== 16'(PHI_BASE) || mute !== 1'b1 || busy !== 1'b0 || cur_ch !== 6'd0) begin
            errors++; $display("FAIL idle_hold: got phi=%0d mute=%b busy=%b ch=%0d expected phi=%0d mute=1 busy=0 ch=0", phi_inc, mute, busy, cur_ch, PHI_BASE);
        end
        $display("reset: phi_inc=%0d mute=%b busy=%b lock=%b cur_ch=%0d", phi_inc, mute, busy, lock, cur_ch);
    endtask

    task automatic test_tune_phi();
        issue(1'b1, 5, 1'b0, 1'b0);
        @(negedge sys_clk);
        checks++; if (busy !== 1'b1 || mute !== 1'b1) begin errors++; $display("FAIL tune5_t1_flags: got busy=%b mute=%b expected busy=1 mute=1", busy, mute); end
        checks++; if (cur_ch !== 6'd5) begin errors++; $display("FAIL tune5_cur_ch: got %0d expected 5", cur_ch); end
        checks++; if (phi_inc !== 16'(PHI_BASE)) begin errors++; $display("FAIL tune5_phi_t1: got %0d expected %0d", phi_inc, PHI_BASE); end
        @(negedge sys_clk);
        checks++; if (phi_inc !== 16'(phi_of(5))) begin errors++; $display("FAIL tune5_phi_t2: got %0d expected %0d", phi_inc, phi_of(5)); end
        $display("tune ch=5: phi_inc=%0d at t+2", phi_inc);
    endtask

    task automatic test_tune_lock();
        int e, ee, ep;
        issue(1'b1, 3, 1'b0, 1'b0);
        measure(150, 150, 100, e, ee, ep);
        checks++; if (e != LATENCY - 1) begin errors++; $display("FAIL tune3_latency: got %0d edges expected %0d", e, LATENCY - 1); end
        checks++; if (pwr !== 13'(ep)) begin errors++; $display("FAIL tune3_pwr: got %0d expected %0d", pwr, ep); end
        checks++; if (lock !== 1'b1 || mute !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL tune3_flags: got lock=%b mute=%b busy=%b expected 1/0/0", lock, mute, busy); end
        checks++; if (cur_ch !== 6'd3 || phi_inc !== 16'(phi_of(3))) begin errors++; $display("FAIL tune3_channel: got ch=%0d phi=%0d expected ch=3 phi=%0d", cur_ch, phi_inc, phi_of(3)); end
        @(negedge sys_clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL tune3_done_width: got %b expected 0", done); end
        $display("tune ch=3: pwr=%0d lock=%b edges=%0d", pwr, lock, e);
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            int ch, amp, vp, e, ee, ep;
            logic exp_lock;
            ch  = int'($urandom_range(CH_MAX));
            amp = (r == 1) ? 100 : 300;
            vp  = 40 + int'($urandom_range(60));
            issue(1'b1, ch, 1'b0, 1'b0);
            if (r == 0) begin
                checks++; if (lock !== 1'b0 || mute !== 1'b1) begin errors++; $display("FAIL rand_lock_clear: got lock=%b mute=%b expected 0/1", lock, mute); end
            end
            measure(-amp, amp, vp, e, ee, ep);
            exp_lock = (ep >= THRESH);
            checks++; if (e < 0 || e != ee) begin errors++; $display("FAIL rand_done_edge: got %0d expected %0d", e, ee); end
            checks++; if (pwr !== 13'(ep)) begin errors++; $display("FAIL rand_pwr: got %0d expected %0d", pwr, ep); end
            checks++; if (lock !== exp_lock || mute !== ~exp_lock) begin errors++; $display("FAIL rand_lock: got lock=%b mute=%b expected lock=%b", lock, mute, exp_lock); end
            checks++; if (cur_ch !== 6'(ch) || phi_inc !== 16'(phi_of(ch))) begin errors++; $display("FAIL rand_channel: got ch=%0d phi=%0d expected ch=%0d phi=%0d", cur_ch, phi_inc, ch, phi_of(ch)); end
            $display("random tune ch=%0d amp=%0d valid%%=%0d: pwr=%0d lock=%b", ch, amp, vp, pwr, lock);
        end
    endtask

    task automatic test_scan(input int start, input int sig, input bit up, input int noise);
        int e, ee, ep, nd, ch, bad;
        bit found;
        issue(1'b1, start, 1'b0, 1'b0);
        measure(0, 0, 100, e, ee, ep);
        checks++; if (e != LATENCY - 1 || lock !== 1'b0) begin errors++; $display("FAIL scan_pretune: got edges=%0d lock=%b expected %0d/0", e, lock, LATENCY - 1); end
        exp_path.delete();
        ch = start;
        found = 1'b0;
        forever begin
            ch = up ? (ch + 1) % (CH_MAX + 1) : (ch + CH_MAX) % (CH_MAX + 1);
            if (ch == start) break;
            exp_path.push_back(phi_of(ch));
            if (ch == sig) begin
                found = 1'b1;
                break;
            end
        end
        issue(1'b0, 0, 1'b1, up);
        scan_drive(sig, noise, e, nd);
        bad = -1;
        for (int i = 0; i < exp_path.size() && i < visited_q.size(); i++) begin
            if (visited_q[i] != exp_path[i] && bad < 0) bad = i;
        end
        checks++; if (e < 0 || visited_q.size() != exp_path.size() || bad >= 0) begin
            errors++; $display("FAIL scan_path: got %0d channels, first diff index %0d, expected %0d channels", visited_q.size(), bad, exp_path.size());
        end
        checks++; if (nd != 1) begin errors++; $display("FAIL scan_done_count: got %0d expected 1", nd); end
        checks++; if (cur_ch !== 6'(found ? sig : start)) begin errors++; $display("FAIL scan_end_ch: got %0d expected %0d", cur_ch, found ? sig : start); end
        checks++; if (lock !== found || mute !== ~found || busy !== 1'b0) begin errors++; $display("FAIL scan_end_flags: got lock=%b mute=%b busy=%b expected lock=%b", lock, mute, busy, found); end
        if (found) begin
            checks++; if (phi_inc !== 16'(phi_of(sig))) begin errors++; $display("FAIL scan_end_phi: got %0d expected %0d", phi_inc, phi_of(sig)); end
        end
        $display("scan from %0d up=%b: visited %0d, cur_ch=%0d lock=%b", start, up, visited_q.size(), cur_ch, lock);
    endtask

    task automatic test_abort();
        int e, ee, ep, st;
        st = int'(cur_ch);
        issue(1'b0, 0, 1'b1, 1'b1);
        checks++; if (cur_ch !== 6'((st + 1) % (CH_MAX + 1)) || busy !== 1'b1) begin errors++; $display("FAIL abort_scan_start: got ch=%0d busy=%b expected ch=%0d busy=1", cur_ch, busy, (st + 1) % (CH_MAX + 1)); end
        repeat (50) @(negedge sys_clk);
        issue(1'b0, 0, 1'b1, 1'b0);
        @(negedge sys_clk);
        checks++; if (cur_ch !== 6'((st + 1) % (CH_MAX + 1)) || busy !== 1'b1) begin errors++; $display("FAIL busy_scan_ignored: got ch=%0d busy=%b expected ch=%0d busy=1", cur_ch, busy, (st + 1) % (CH_MAX + 1)); end
        issue(1'b1, 9, 1'b0, 1'b0);
        checks++; if (cur_ch !== 6'd9) begin errors++; $display("FAIL abort_cur_ch: got %0d expected 9", cur_ch); end
        measure(0, 0, 100, e, ee, ep);
        checks++; if (e != LATENCY - 1) begin errors++; $display("FAIL abort_latency: got %0d expected %0d", e, LATENCY - 1); end
        checks++; if (phi_inc !== 16'(phi_of(9)) || lock !== 1'b0) begin errors++; $display("FAIL abort_result: got phi=%0d lock=%b expected phi=%0d lock=0", phi_inc, lock, phi_of(9)); end
        repeat (20) @(negedge sys_clk);
        checks++; if (busy !== 1'b0 || cur_ch !== 6'd9) begin errors++; $display("FAIL abort_stays: got busy=%b ch=%0d expected 0/9", busy, cur_ch); end
        $display("abort: tune ch=9 during scan, phi_inc=%0d", phi_inc);
    endtask

    task automatic test_overflow_clamp();
        int e, ee, ep;
        issue(1'b1, 40, 1'b1, 1'b1);
        checks++; if (cur_ch !== 6'(CH_MAX)) begin errors++; $display("FAIL clamp_cur_ch: got %0d expected %0d", cur_ch, CH_MAX); end
        measure(-2048, -2048, 100, e, ee, ep);
        checks++; if (pwr !== 13'(ep) || ep != 4096) begin errors++; $display("FAIL overflow_pwr: got %0d expected 4096", pwr); end
        checks++; if (e != LATENCY - 1 || lock !== 1'b1) begin errors++; $display("FAIL clamp_tune_wins: got edges=%0d lock=%b expected %0d/1", e, lock, LATENCY - 1); end
        checks++; if (phi_inc !== 16'(phi_of(CH_MAX))) begin errors++; $display("FAIL clamp_phi: got %0d expected %0d", phi_inc, phi_of(CH_MAX)); end
        $display("clamp tune ch=40: cur_ch=%0d pwr=%0d lock=%b", cur_ch, pwr, lock);
    endtask

    task automatic test_async_reset();
        issue(1'b1, 12, 1'b0, 1'b0);
        repeat (100) @(negedge sys_clk);
        #2;
        sys_rst = 1'b0;
        #1;
        checks++; if (phi_inc !== 16'(PHI_BASE) || busy !== 1'b0 || mute !== 1'b1 || cur_ch !== 6'd0 || pwr !== 13'd0 || lock !== 1'b0) begin
            errors++; $display("FAIL async_reset: got phi=%0d busy=%b mute=%b ch=%0d pwr=%0d lock=%b expected reset values", phi_inc, busy, mute, cur_ch, pwr, lock);
        end
        @(negedge sys_clk);
        sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        checks++; if (busy !== 1'b0 || phi_inc !== 16'(PHI_BASE)) begin errors++; $display("FAIL post_reset_idle: got busy=%b phi=%0d expected 0/%0d", busy, phi_inc, PHI_BASE); end
        $display("async reset mid-settle: phi_inc=%0d busy=%b", phi_inc, busy);
    endtask

    initial begin
        sys_rst  = 1'b0;
        tune_req = 1'b0;
        tune_ch  = 6'd0;
        scan_req = 1'b0;
        scan_up  = 1'b0;
        iq_valid = 1'b0;
        i_data   = '0;
        q_data   = '0;
        test_reset();
        test_tune_phi();
        test_tune_lock();
        test_random();
        test_scan(30, 1, 1'b1, 40);
        test_scan(7, -1, 1'($urandom_range(1)), 0);
        test_abort();
        test_overflow_clamp();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
